pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB).
//  Detects load-use hazards, squashes wrong-path instructions on a taken branch, and runs a
//  variable-latency data-memory handshake. While memory is busy it freezes the upstream stages
//  and feeds bubbles into MEM_WB. Sits beside the datapath and drives every pipeline-register Enable/flush.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles in MWAIT before forced release (>=1)
//  CNT_W        32  width of the stall_cycles performance counter
// PORTS
//  clk             in   1      pipeline clock, all state on posedge
//  rst             in   1      synchronous, active-high reset
//  IF_ID_rs        in   5      rs field of instruction in ID
//  IF_ID_rt        in   5      rt field of instruction in ID
//  IF_ID_use_rt    in   1      ID instruction reads rt as a source
//  ID_EX_MemRead   in   1      instruction in EX is a load
//  ID_EX_rt        in   5      load destination register in EX
//  EX_branch_taken in   1      branch/jump resolved taken in EX
//  EX_MEM_MemAcc   in   1      instruction in MEM reads or writes data memory
//  dmem_ready      in   1      data memory completes the current access this cycle
//  dmem_req        out  1      data memory access request
//  PC_en           out  1      PC update enable
//  IF_ID_en        out  1      IF_ID register Enable
//  IF_ID_flush     out  1      load NOP into IF_ID
//  ID_EX_en        out  1      ID_EX register Enable
//  ID_EX_flush     out  1      load bubble (RegWrite=0, MemRead/MemWrite=0) into ID_EX
//  EX_MEM_en       out  1      EX_MEM register Enable
//  MEM_WB_en       out  1      MEM_WB register Enable (always 1 outside reset)
//  MEM_WB_bubble   out  1      force MEM_WB_RegWrite=0 on this capture
//  mem_err         out  1      sticky: an access hit MEM_TIMEOUT
//  stall_cycles    out  CNT_W  count of cycles with PC_en=0
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state<=RUN, wait_cnt<=0, mem_err<=0, stall_cycles<=0. While rst=1
//    all outputs are combinationally held at: *_en=0, IF_ID_flush=ID_EX_flush=MEM_WB_bubble=1, dmem_req=0.
//  - State register: RUN, MWAIT. Outputs are combinational from state + inputs (0-cycle latency).
//  - Default (RUN, no events): all *_en=1, all flush/bubble=0, dmem_req=EX_MEM_MemAcc.
//  - Priority (highest first): memory stall > branch flush > load-use stall.
//  - Memory, RUN: EX_MEM_MemAcc=1 -> dmem_req=1. If dmem_ready=1 same cycle: no stall.
//    Otherwise: PC_en=IF_ID_en=ID_EX_en=EX_MEM_en=0, MEM_WB_bubble=1, next state MWAIT, wait_cnt<=1.
//  - MWAIT: dmem_req=1, same freeze + bubble, wait_cnt++ each cycle. On dmem_ready=1: all enables=1,
//    MEM_WB_bubble=0 (result captured), state<=RUN, wait_cnt<=0. If wait_cnt==MEM_TIMEOUT without ready:
//    mem_err<=1, release exactly as on ready (the captured data is undefined), state<=RUN.
//  - Branch (EX_branch_taken=1, no memory stall): IF_ID_flush=1, ID_EX_flush=1, all enables=1.
//    A branch arriving during MWAIT is held frozen in EX and acted on in the release cycle.
//  - Load-use (ID_EX_MemRead=1, ID_EX_rt!=0, and ID_EX_rt==IF_ID_rs or (IF_ID_use_rt and
//    ID_EX_rt==IF_ID_rt)), no higher event: PC_en=IF_ID_en=0, ID_EX_flush=1; downstream enabled.
//    Exactly one stall cycle per hazard (the load advances, so the condition clears).
//  - Rule: a flush overrides its enable; a flushed register loads its bubble on that edge.
//  - stall_cycles increments when PC_en=0 and rst=0; saturates at all-ones (no wrap).
//  - Reset mid-MWAIT: dmem_req drops the same cycle, state->RUN; the memory must discard the access.
// STRUCTURE
//  - Shared pipeline package/header: state encodings (ST_RUN, ST_MWAIT), REG_ZERO=5'd0, and the
//    NOP/bubble constants reused by the IF_ID/ID_EX flush logic.
//  - One natural sub-module: hazard_detect (combinational load-use compare) -> load_use_stall.
//  - FSM, wait counter, mem_err and the perf counter stay in the top module.
// TESTING
//  1 Reset: rst=1 two cycles -> all enables 0, flushes 1, stall_cycles=0, mem_err=0; release -> defaults.
//  2 Load-use: ID_EX_MemRead=1, ID_EX_rt=5, IF_ID_rs=5 -> one cycle PC_en=0, ID_EX_flush=1; rt=0 -> no stall.
//  3 Branch: EX_branch_taken=1 -> IF_ID_flush=ID_EX_flush=1 for one cycle, PC_en=1, stall_cycles unchanged.
//  4 Mem wait: MemAcc=1, ready after 3 cycles -> 3 frozen cycles with MEM_WB_bubble=1, stall_cycles+=3, capture on ready.
//  5 Timeout: MEM_TIMEOUT=4, ready never -> release after 4 wait cycles, mem_err=1 and sticky until rst.
//  6 Collision: branch + load-use + mem stall in the same cycle -> memory freeze wins; branch flush on release.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline-control types: sequencer states, the zero-register index and the
// enable/flush pairs each pipeline register can be driven with.
package pipe_stall_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_MWAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Enable/flush pair for one pipeline register; a set flush loads the NOP/bubble.
    typedef struct packed {
        logic en;
        logic flush;
    } reg_ctl_t;

    localparam reg_ctl_t REG_ADVANCE = '{en: 1'b1, flush: 1'b0};
    localparam reg_ctl_t REG_HOLD    = '{en: 1'b0, flush: 1'b0};
    localparam reg_ctl_t REG_SQUASH  = '{en: 1'b1, flush: 1'b1};
    localparam reg_ctl_t REG_RESET   = '{en: 1'b0, flush: 1'b1};

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the instruction in ID reads.
module pipe_stall_ctrl_hazard_detect
    import pipe_stall_ctrl_pkg::*;
(
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_rt,
    input  logic [4:0] IF_ID_rs,
    input  logic [4:0] IF_ID_rt,
    input  logic       IF_ID_use_rt,
    output logic       load_use_stall
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ID_EX_rt == IF_ID_rs);
    assign rt_match = IF_ID_use_rt && (ID_EX_rt == IF_ID_rt);

    // Writes to the zero register are discarded, so they never create a dependency.
    assign load_use_stall = ID_EX_MemRead && (ID_EX_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: memory-wait freeze, branch squash and load-use stall
// for the IF_ID / ID_EX / EX_MEM / MEM_WB pipeline registers.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_use_rt,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rt,
    input  logic             EX_branch_taken,
    input  logic             EX_MEM_MemAcc,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             PC_en,
    output logic             IF_ID_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_en,
    output logic             ID_EX_flush,
    output logic             EX_MEM_en,
    output logic             MEM_WB_en,
    output logic             MEM_WB_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              timeout;
    logic              mem_stall;
    logic              load_use_stall;
    reg_ctl_t          if_id_ctl;
    reg_ctl_t          id_ex_ctl;

    pipe_stall_ctrl_hazard_detect u_hazard_detect (
        .ID_EX_MemRead  (ID_EX_MemRead),
        .ID_EX_rt       (ID_EX_rt),
        .IF_ID_rs       (IF_ID_rs),
        .IF_ID_rt       (IF_ID_rt),
        .IF_ID_use_rt   (IF_ID_use_rt),
        .load_use_stall (load_use_stall)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        timeout       = 1'b0;
        mem_stall     = 1'b0;
        dmem_req      = EX_MEM_MemAcc;
        PC_en         = 1'b1;
        if_id_ctl     = REG_ADVANCE;
        id_ex_ctl     = REG_ADVANCE;
        EX_MEM_en     = 1'b1;
        MEM_WB_en     = 1'b1;
        MEM_WB_bubble = 1'b0;

        case (state)
            ST_RUN: begin
                if (EX_MEM_MemAcc && !dmem_ready) begin
                    mem_stall    = 1'b1;
                    state_nxt    = ST_MWAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            ST_MWAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    // Forced release: MEM_WB captures whatever the bus holds.
                    timeout      = 1'b1;
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    mem_stall    = 1'b1;
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
        endcase

        // A branch or hazard seen during the wait is still in EX/ID at release and is handled then.
        if (mem_stall) begin
            PC_en         = 1'b0;
            if_id_ctl     = REG_HOLD;
            id_ex_ctl     = REG_HOLD;
            EX_MEM_en     = 1'b0;
            MEM_WB_bubble = 1'b1;
        end else if (EX_branch_taken) begin
            if_id_ctl = REG_SQUASH;
            id_ex_ctl = REG_SQUASH;
        end else if (load_use_stall) begin
            PC_en     = 1'b0;
            if_id_ctl = REG_HOLD;
            id_ex_ctl = REG_SQUASH;
        end

        // Reset drops dmem_req immediately; an access in flight is abandoned.
        if (rst) begin
            state_nxt     = ST_RUN;
            wait_cnt_nxt  = '0;
            timeout       = 1'b0;
            dmem_req      = 1'b0;
            PC_en         = 1'b0;
            if_id_ctl     = REG_RESET;
            id_ex_ctl     = REG_RESET;
            EX_MEM_en     = 1'b0;
            MEM_WB_en     = 1'b0;
            MEM_WB_bubble = 1'b1;
        end
    end

    assign IF_ID_en    = if_id_ctl.en;
    assign IF_ID_flush = if_id_ctl.flush;
    assign ID_EX_en    = id_ex_ctl.en;
    assign ID_EX_flush = id_ex_ctl.flush;

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state        <= ST_RUN;
            wait_cnt     <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout) begin
                mem_err <= 1'b1;
            end
            if (!PC_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed vector table, hand sequences for multi-cycle
// corners, then random stimulus against a cycle-level reference model.
module tb_pipe_stall_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // Output vector order: {dmem_req, PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush,
    //                       EX_MEM_en, MEM_WB_en, MEM_WB_bubble}
    localparam logic [8:0] O_RESET   = 9'b0_0_0_1_0_1_0_0_1;
    localparam logic [8:0] O_DEFAULT = 9'b0_1_1_0_1_0_1_1_0;
    localparam logic [8:0] O_LOADUSE = 9'b0_0_0_0_1_1_1_1_0;
    localparam logic [8:0] O_BRANCH  = 9'b0_1_1_1_1_1_1_1_0;
    localparam logic [8:0] O_MEMOK   = 9'b1_1_1_0_1_0_1_1_0;
    localparam logic [8:0] O_FREEZE  = 9'b1_0_0_0_0_0_0_1_1;
    localparam logic [8:0] O_REL_BR  = 9'b1_1_1_1_1_1_1_1_0;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rt;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic       memacc;
        logic       ready;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [8:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       if_id_rs, if_id_rt, id_ex_rt;
    logic             if_id_use_rt, id_ex_memread, ex_branch_taken, ex_mem_memacc, dmem_ready;
    logic             dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic             ex_mem_en, mem_wb_en, mem_wb_bubble, mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [8:0]       act;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: an outstanding access and how many cycles it has frozen the pipe.
    bit m_waiting = 1'b0;
    int m_frozen  = 0;
    bit m_err     = 1'b0;
    int m_stalls  = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .IF_ID_rs        (if_id_rs),
        .IF_ID_rt        (if_id_rt),
        .IF_ID_use_rt    (if_id_use_rt),
        .ID_EX_MemRead   (id_ex_memread),
        .ID_EX_rt        (id_ex_rt),
        .EX_branch_taken (ex_branch_taken),
        .EX_MEM_MemAcc   (ex_mem_memacc),
        .dmem_ready      (dmem_ready),
        .dmem_req        (dmem_req),
        .PC_en           (pc_en),
        .IF_ID_en        (if_id_en),
        .IF_ID_flush     (if_id_flush),
        .ID_EX_en        (id_ex_en),
        .ID_EX_flush     (id_ex_flush),
        .EX_MEM_en       (ex_mem_en),
        .MEM_WB_en       (mem_wb_en),
        .MEM_WB_bubble   (mem_wb_bubble),
        .mem_err         (mem_err),
        .stall_cycles    (stall_cycles)
    );

    assign act = {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                  ex_mem_en, mem_wb_en, mem_wb_bubble};

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    function automatic in_t mk(input bit r, input int rs, input int rt, input bit use_rt,
                               input bit memread, input int ex_rt, input bit br,
                               input bit memacc, input bit ready);
        in_t v;
        v.rst     = r;
        v.rs      = 5'(rs);
        v.rt      = 5'(rt);
        v.use_rt  = use_rt;
        v.memread = memread;
        v.ex_rt   = 5'(ex_rt);
        v.br      = br;
        v.memacc  = memacc;
        v.ready   = ready;
        return v;
    endfunction

    // Expected combinational outputs from the priority rules: memory freeze > branch > load-use.
    function automatic logic [8:0] model_out(input in_t v);
        bit freeze, hazard, req;
        logic [8:0] o;
        if (v.rst) return O_RESET;
        req    = m_waiting ? 1'b1 : v.memacc;
        freeze = m_waiting ? (!v.ready && m_frozen < MEM_TIMEOUT) : (v.memacc && !v.ready);
        hazard = v.memread && (v.ex_rt != 0) &&
                 ((v.ex_rt == v.rs) || (v.use_rt && (v.ex_rt == v.rt)));
        if (freeze)      o = O_FREEZE;
        else if (v.br)   o = O_BRANCH;
        else if (hazard) o = O_LOADUSE;
        else             o = O_DEFAULT;
        o[8] = req;
        return o;
    endfunction

    task automatic model_step(input in_t v, input logic [8:0] o);
        if (v.rst) begin
            m_waiting = 1'b0;
            m_frozen  = 0;
            m_err     = 1'b0;
            m_stalls  = 0;
        end else begin
            if (!o[7]) m_stalls = (m_stalls + 1 > CNT_MAX) ? CNT_MAX : m_stalls + 1;
            if (m_waiting) begin
                if (v.ready) begin
                    m_waiting = 1'b0;
                end else if (m_frozen == MEM_TIMEOUT) begin
                    m_err     = 1'b1;
                    m_waiting = 1'b0;
                end else begin
                    m_frozen++;
                end
            end else if (v.memacc && !v.ready) begin
                m_waiting = 1'b1;
                m_frozen  = 1;
            end
        end
    endtask

    // Called just after a posedge: drive, compare at the falling edge, advance one cycle.
    task automatic drive(input in_t v, input bit has_exp, input logic [8:0] tbl_exp);
        logic [8:0] m;
        rst             = v.rst;
        if_id_rs        = v.rs;
        if_id_rt        = v.rt;
        if_id_use_rt    = v.use_rt;
        id_ex_memread   = v.memread;
        id_ex_rt        = v.ex_rt;
        ex_branch_taken = v.br;
        ex_mem_memacc   = v.memacc;
        dmem_ready      = v.ready;
        @(negedge clk);
        m = model_out(v);
        if (has_exp) check("table_outputs", 64'(act), 64'(tbl_exp));
        check("model_outputs", 64'(act), 64'(m));
        check("stall_cycles", 64'(stall_cycles), 64'(m_stalls));
        check("mem_err", 64'(mem_err), 64'(m_err));
        model_step(v, m);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input in_t v);
        drive(v, 1'b0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [15];
        in_t  idle, lu_rs, mem_wait, mem_done;
        int   base;

        idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu_rs    = mk(0, 5, 0, 0, 1, 5, 0, 0, 0);
        mem_wait = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        mem_done = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);

        tbl[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0), O_RESET};
        tbl[1]  = '{mk(1, 5, 0, 0, 1, 5, 1, 1, 0), O_RESET};
        tbl[2]  = '{idle, O_DEFAULT};
        tbl[3]  = '{lu_rs, O_LOADUSE};
        tbl[4]  = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0), O_DEFAULT};
        tbl[5]  = '{mk(0, 3, 7, 1, 1, 7, 0, 0, 0), O_LOADUSE};
        tbl[6]  = '{mk(0, 3, 7, 0, 1, 7, 0, 0, 0), O_DEFAULT};
        tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0), O_BRANCH};
        tbl[8]  = '{mk(0, 5, 0, 0, 1, 5, 1, 0, 0), O_BRANCH};
        tbl[9]  = '{mem_done, O_MEMOK};
        tbl[10] = '{mem_wait, O_FREEZE};
        tbl[11] = '{mem_wait, O_FREEZE};
        tbl[12] = '{mem_wait, O_FREEZE};
        tbl[13] = '{mem_done, O_MEMOK};
        tbl[14] = '{idle, O_DEFAULT};

        rst = 1'b1;
        {if_id_rs, if_id_rt, id_ex_rt} = '0;
        {if_id_use_rt, id_ex_memread, ex_branch_taken, ex_mem_memacc, dmem_ready} = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) drive(tbl[i].in, 1'b1, tbl[i].exp);
        check("stall_after_table", 64'(stall_cycles), 64'd5);

        // Collision: memory freeze wins over branch and load-use; branch squash on release.
        base = int'(stall_cycles);
        drive(mk(0, 5, 0, 0, 1, 5, 1, 1, 0), 1'b1, O_FREEZE);
        drive(mk(0, 5, 0, 0, 1, 5, 1, 1, 0), 1'b1, O_FREEZE);
        drive(mk(0, 5, 0, 0, 1, 5, 1, 1, 1), 1'b1, O_REL_BR);
        drive(idle, 1'b1, O_DEFAULT);
        check("collision_stalls", 64'(int'(stall_cycles) - base), 64'd2);

        // Timeout: ready never arrives; release after MEM_TIMEOUT frozen cycles, error is sticky.
        base = int'(stall_cycles);
        for (int i = 0; i < MEM_TIMEOUT; i++) drive(mem_wait, 1'b1, O_FREEZE);
        drive(mem_wait, 1'b1, O_MEMOK);
        drive(idle, 1'b1, O_DEFAULT);
        check("timeout_stalls", 64'(int'(stall_cycles) - base), 64'(MEM_TIMEOUT));
        check("mem_err_set", 64'(mem_err), 64'd1);
        for (int i = 0; i < 5; i++) run(idle);
        check("mem_err_sticky", 64'(mem_err), 64'd1);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, O_RESET);
        drive(idle, 1'b1, O_DEFAULT);
        check("mem_err_cleared", 64'(mem_err), 64'd0);

        // Reset during a wait: request drops at once and the sequencer returns to RUN.
        drive(mem_wait, 1'b1, O_FREEZE);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, O_RESET);
        drive(idle, 1'b1, O_DEFAULT);

        // Saturation: a held hazard stalls every cycle; the counter must stop at all-ones.
        for (int i = 0; i < CNT_MAX + 40; i++) run(lu_rs);
        check("stall_saturated", 64'(stall_cycles), 64'(CNT_MAX));
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, O_RESET);

        for (int i = 0; i < 3000; i++) begin
            run(mk($urandom_range(0, 63) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                   $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
